// File: rtl/div3_pkg.sv
// Shared types and the residue step for the divisible-by-3 serial stream.
// Used by the transmitter, the serial detector model and the scoreboard.
package div3_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef logic [1:0] residue_t;

    // Appending bit b to a prefix with residue r gives (2*r + b) mod 3.
    function automatic residue_t mod3_step(residue_t r, logic b);
        residue_t n;
        case (r)
            2'd0:    n = b ? 2'd1 : 2'd0;
            2'd1:    n = b ? 2'd0 : 2'd2;
            default: n = b ? 2'd2 : 2'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/div3_stream_tx.sv
// Serializes a word MSB-first with frame markers, alongside the golden
// "prefix divisible by 3" flag and residue for each emitted bit.
module div3_stream_tx
    import div3_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic [LW-1:0]    len_i,
    output logic             x_valid_o,
    input  logic             x_ready_i,
    output logic             x_o,
    output logic             sof_o,
    output logic             eof_o,
    output logic             div_o,
    output logic [1:0]       rem_o,
    output logic             busy_o
);

    localparam logic [LW-1:0] LEN_MAX = LW'(WIDTH);

    state_t           state_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic [LW-1:0]    cnt_reg;
    logic [LW-1:0]    len_reg;
    residue_t         res_reg;

    logic [LW-1:0]    len_eff;
    residue_t         res_next;
    logic             shifting;
    logic             eof;
    logic             beat;
    logic             accept;

    // Zero and oversize lengths both mean a full-width frame.
    always_comb begin
        len_eff = len_i;
        if (len_i == '0 || len_i > LEN_MAX)
            len_eff = LEN_MAX;
    end

    assign shifting = (state_reg == SHIFT);
    assign eof      = shifting && (cnt_reg == LW'(1));
    assign beat     = shifting && x_ready_i;
    assign res_next = mod3_step(res_reg, shreg_reg[WIDTH-1]);

    // Accepting on the eof beat lets frames run back to back.
    assign in_ready_o = !shifting || (eof && x_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    assign x_valid_o = shifting;
    assign busy_o    = shifting;
    assign x_o       = shifting & shreg_reg[WIDTH-1];
    assign sof_o     = shifting && (cnt_reg == len_reg);
    assign eof_o     = eof;
    assign rem_o     = shifting ? res_next : 2'd0;
    assign div_o     = shifting && (res_next == 2'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            cnt_reg   <= '0;
            len_reg   <= '0;
            res_reg   <= 2'd0;
        end else if (accept) begin
            // Left-justify the frame so its MSB sits at the output bit.
            shreg_reg <= data_i << (LEN_MAX - len_eff);
            cnt_reg   <= len_eff;
            len_reg   <= len_eff;
            res_reg   <= 2'd0;
            state_reg <= SHIFT;
        end else if (beat) begin
            shreg_reg <= {shreg_reg[WIDTH-2:0], 1'b0};
            cnt_reg   <= cnt_reg - LW'(1);
            res_reg   <= res_next;
            if (eof)
                state_reg <= IDLE;
        end
    end

endmodule

// File: tb/tb_div3_stream_tx.sv
// Directed bench for div3_stream_tx: frame contents, stalls, back-to-back
// frames and mid-frame reset, all against hand-computed sequences.
module tb_div3_stream_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] data_i;
    logic [3:0] len_i;
    logic       x_valid_o;
    logic       x_ready_i;
    logic       x_o;
    logic       sof_o;
    logic       eof_o;
    logic       div_o;
    logic [1:0] rem_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    div3_stream_tx #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .data_i     (data_i),
        .len_i      (len_i),
        .x_valid_o  (x_valid_o),
        .x_ready_i  (x_ready_i),
        .x_o        (x_o),
        .sof_o      (sof_o),
        .eof_o      (eof_o),
        .div_o      (div_o),
        .rem_o      (rem_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Packed view of the output side: {in_ready, x_valid, busy, x, sof, eof, div, rem}
    function automatic logic [15:0] outs();
        return {7'd0, in_ready_o, x_valid_o, busy_o, x_o, sof_o, eof_o, div_o, rem_o};
    endfunction

    function automatic logic [15:0] beat_exp(logic rdy, logic x, logic sof, logic eof, logic [1:0] rem);
        return {7'd0, rdy, 1'b1, 1'b1, x, sof, eof, (rem == 2'd0), rem};
    endfunction

    localparam logic [15:0] IDLE_OUTS = 16'h0100;

    task automatic offer(input logic [7:0] d, input logic [3:0] l);
        data_i     = d;
        len_i      = l;
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        data_i     = 8'hxx;
    endtask

    // xs: expected bits, first bit at xs[7]; rems: beat i at rems[15-2i -: 2].
    // stall_at: beat index held with x_ready low for stall_n extra cycles (-1 none).
    task automatic run_frame(input string tag, input logic [7:0] d, input logic [3:0] l,
                             input int n, input logic [7:0] xs, input logic [15:0] rems,
                             input int stall_at, input int stall_n);
        offer(d, l);
        for (int i = 0; i < n; i++) begin
            logic [1:0] r;
            r = rems[15-2*i -: 2];
            if (i == stall_at) begin
                x_ready_i = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    chk($sformatf("%s stall%0d beat%0d", tag, s, i + 1), outs(),
                        beat_exp(1'b0, xs[7-i], i == 0, i == n - 1, r));
                    step();
                end
                x_ready_i = 1'b1;
            end
            chk($sformatf("%s beat%0d", tag, i + 1), outs(),
                beat_exp(i == n - 1, xs[7-i], i == 0, i == n - 1, r));
            step();
        end
        chk({tag, " idle"}, outs(), IDLE_OUTS);
    endtask

    initial begin
        reset      = 1'b1;
        in_valid_i = 1'b0;
        x_ready_i  = 1'b1;
        data_i     = 8'h00;
        len_i      = 4'd0;
        #1;
        chk("reset async", outs(), IDLE_OUTS);
        step();
        step();
        chk("reset held", outs(), IDLE_OUTS);
        reset = 1'b0;
        step();
        chk("post reset", outs(), IDLE_OUTS);

        // D7 = 1101_0111: residues 1,0,0,1,2,2,2,2
        run_frame("d7", 8'hD7, 4'd8, 8, 8'b1101_0111, 16'b01_00_00_01_10_10_10_10, -1, 0);
        // Low 3 bits of FE = 110
        run_frame("fe3", 8'hFE, 4'd3, 3, 8'b1100_0000, 16'b01_00_00_00_00_00_00_00, -1, 0);
        run_frame("zero0", 8'h00, 4'd0, 8, 8'h00, 16'h0000, -1, 0);
        run_frame("one1", 8'h01, 4'd1, 1, 8'b1000_0000, 16'b01_00_00_00_00_00_00_00, -1, 0);
        // Oversize length clamps to a full frame
        run_frame("clamp", 8'hD7, 4'd12, 8, 8'b1101_0111, 16'b01_00_00_01_10_10_10_10, -1, 0);
        // Beat 3 (x=0, rem 0) held for 2 stall cycles plus its taken cycle
        run_frame("stall", 8'hD7, 4'd8, 8, 8'b1101_0111, 16'b01_00_00_01_10_10_10_10, 2, 2);

        // Back-to-back: 06/len3 offered mid-frame, accepted only on the eof beat
        begin
            logic [7:0]  xs;
            logic [15:0] rems;
            xs   = 8'b1101_0111;
            rems = 16'b01_00_00_01_10_10_10_10;
            offer(8'hD7, 4'd8);
            for (int i = 0; i < 8; i++) begin
                if (i == 3) begin
                    data_i     = 8'h06;
                    len_i      = 4'd3;
                    in_valid_i = 1'b1;
                end
                chk($sformatf("b2b a beat%0d", i + 1), outs(),
                    beat_exp(i == 7, xs[7-i], i == 0, i == 7, rems[15-2*i -: 2]));
                step();
            end
            in_valid_i = 1'b0;
            chk("b2b b beat1", outs(), beat_exp(1'b0, 1'b1, 1'b1, 1'b0, 2'd1));
            step();
            chk("b2b b beat2", outs(), beat_exp(1'b0, 1'b1, 1'b0, 1'b0, 2'd0));
            step();
            chk("b2b b beat3", outs(), beat_exp(1'b1, 1'b0, 1'b0, 1'b1, 2'd0));
            step();
            chk("b2b idle", outs(), IDLE_OUTS);
        end

        // Reset after four beats of D7 drops the frame
        offer(8'hD7, 4'd8);
        for (int i = 0; i < 4; i++) step();
        chk("rst beat5", outs(), beat_exp(1'b0, 1'b0, 1'b0, 1'b0, 2'd2));
        reset = 1'b1;
        #1;
        chk("rst async", outs(), IDLE_OUTS);
        step();
        reset = 1'b0;
        step();
        chk("rst released", outs(), IDLE_OUTS);
        run_frame("rst 03", 8'h03, 4'd2, 2, 8'b1100_0000, 16'b01_00_00_00_00_00_00_00, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div3_stream_tx.md
Name: div3_stream_tx

Overview:
- Transmit end of the serial divisible-by-3 bit stream.
- Accepts a parallel word plus a length on a valid/ready input handshake.
- Serializes the word MSB-first, one bit per accepted output beat, with frame markers.
- Alongside each bit it drives the golden "prefix divisible by 3" flag and residue, so the stream can drive the serial detector directly and be checked bit for bit.

Parameters:
- WIDTH, 8, maximum frame length in bits and data_i width.
- LW, $clog2(WIDTH+1), width of len_i.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  word offered.
- in_ready_o  out  1  word can be accepted this cycle.
- data_i  in  WIDTH  word; the low len bits are the frame, higher bits ignored.
- len_i  in  LW  frame length in bits; 0 means WIDTH; values above WIDTH are clamped to WIDTH.
- x_valid_o  out  1  x_o carries a frame bit.
- x_ready_i  in  1  sink takes the bit this cycle.
- x_o  out  1  serial bit, MSB of frame first.
- sof_o  out  1  current bit is the first of its frame.
- eof_o  out  1  current bit is the last of its frame.
- div_o  out  1  frame prefix up to and including x_o is divisible by 3.
- rem_o  out  2  that prefix mod 3 (0..2).
- busy_o  out  1  frame in progress.

Behaviour:
- FSM states: IDLE, SHIFT.
- Reset (async assert, synchronous-release usage): state=IDLE, shift register=0, cnt=0, residue=0.
  - All outputs read 0 during reset except in_ready_o=1.
  - A frame in flight is dropped silently; no eof_o is emitted.
- IDLE:
  - in_ready_o=1.
  - Accept when in_valid_i is high at the edge: shreg <= data_i << (WIDTH-len), cnt <= len, residue <= 0, state <= SHIFT.
- SHIFT:
  - x_valid_o=1, busy_o=1, x_o=shreg[WIDTH-1].
  - sof_o=1 while cnt equals the loaded len.
  - eof_o=(cnt==1).
- Residue step, combinational, res_n = (2*res + x_o) mod 3:
  - res 0: x=0 -> 0, x=1 -> 1.
  - res 1: x=0 -> 2, x=1 -> 0.
  - res 2: x=0 -> 1, x=1 -> 2.
  - rem_o=res_n and div_o=(res_n==0), both valid while x_valid_o=1, else 0.
- Beat is taken when x_valid_o && x_ready_i: shreg <<= 1, cnt--, residue <= res_n.
- Stall (x_ready_i=0): x_o, sof_o, eof_o, div_o, rem_o and all state hold unchanged.
- End of frame: when the eof beat is taken, return to IDLE unless a new word is accepted on the same edge.
- in_ready_o = IDLE | (SHIFT & eof_o & x_ready_i).
  - This allows back-to-back frames with no bubble.
  - The new frame's sof_o appears the cycle after the previous frame's eof beat.
- Latency: word accepted at edge k -> first bit visible after edge k; with x_ready_i held high the last bit is visible after edge k+len-1.
- in_valid_i while busy and not on the eof beat: not accepted; the upstream holds the word.
- sof_o and eof_o are both high when len=1.

Decomposition:
- div3_pkg holds:
  - state_t enum {IDLE, SHIFT}.
  - residue_t logic [1:0].
  - Function mod3_step(residue_t r, logic b) returning residue_t, shared with the detector model and the scoreboard.
- No sub-module is needed: one FSM, shift register, counter and residue register.

Test Plan:
- Frame, len 8, data 8'hD7, x_ready_i=1:
  - x_o = 1,1,0,1,0,1,1,1.
  - div_o = 0,1,1,0,0,0,0,0.
  - rem_o = 1,0,0,1,2,2,2,2.
  - sof_o on beat 1, eof_o on beat 8, in_ready_o=1 on beat 8.
- Frame, len 3, data 8'hFE:
  - x_o = 1,1,0 and div_o = 0,1,1.
  - Upper data bits ignored; sof_o on beat 1, eof_o on beat 3.
- Frame, len 0, data 8'h00:
  - 8 beats of x_o=0, div_o=1, rem_o=0.
  - len=1 with data 8'h01: single beat, sof_o=eof_o=1, div_o=0, rem_o=1.
- Stall: 8'hD7 with x_ready_i low for 2 cycles after beat 2:
  - x_o=0, div_o=1, rem_o=0 held for 3 cycles.
  - Remaining sequence unchanged, eof_o on beat 8.
- Back-to-back: 8'hD7 then len 3 / 8'h06 offered during the first frame:
  - Second word accepted on the eof beat.
  - Next cycle sof_o=1, x_o=1, rem_o=1 (residue restarted).
  - No idle cycle between the frames.
- Reset mid-frame: assert reset after beat 4 of 8'hD7:
  - Outputs 0 immediately (async); in_ready_o=1.
  - After release, a new frame 8'h03 (len 2) yields div_o = 0,1.
